// File: rtl/mbr_unit_pkg.sv
// Shared constants and helpers for the memory bank register unit.
// The unit supplies the 8 extended address bits that sit above the 16-bit address.
package mbr_unit_pkg;

    localparam int MB_COUNT = 8;
    localparam int MB_WIDTH = 8;

    localparam logic [4:0] WADDR_WRITE_MBN   = 5'b01111;
    localparam logic [4:0] RADDR_READ_MBN    = 5'b01111;
    localparam logic [2:0] WADDR_WRITE_AR_MB = 3'b001;

    localparam logic [1:0] MB_CODE_P = 2'b00;
    localparam logic [1:0] MB_CODE_D = 2'b01;
    localparam logic [1:0] MB_CODE_S = 2'b10;
    localparam logic [1:0] MB_CODE_Z = 2'b11;

    // Until a low bank has been written, every bank reads as the power-on map default.
    function automatic logic [7:0] mbr_value(input logic enabled, input logic [7:0] mb,
                                             input logic rom_mode);
        return enabled ? mb : {rom_mode, 7'b0};
    endfunction

endpackage

// File: rtl/mbr_regfile.sv
// 8x8 bank register file: one synchronous write port, two asynchronous read ports.
module mbr_regfile
    import mbr_unit_pkg::*;
(
    input  logic                clk,
    input  logic                nreset,
    input  logic                we,
    input  logic [2:0]          waddr,
    input  logic [MB_WIDTH-1:0] wdata,
    input  logic [2:0]          raddr_a,
    output logic [MB_WIDTH-1:0] rdata_a,
    input  logic [2:0]          raddr_b,
    output logic [MB_WIDTH-1:0] rdata_b
);

    logic [MB_WIDTH-1:0] mb [MB_COUNT];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < MB_COUNT; i++) begin
                mb[i] <= '0;
            end
        end else if (we) begin
            mb[waddr] <= wdata;
        end
    end

    assign rdata_a = mb[raddr_a];
    assign rdata_b = mb[raddr_b];

endmodule

// File: rtl/mbr_unit.sv
// Memory bank register unit: bank registers on IBUS, AEXT bank select for AR loads,
// and a front-panel mirror of AEXT.
module mbr_unit
    import mbr_unit_pkg::*;
(
    input  logic        clk,
    input  logic        nreset,
    input  logic [4:0]  waddr,
    input  logic [4:0]  raddr,
    input  logic [11:0] ir,
    inout  wire  [7:0]  ibus,
    output logic [7:0]  aext,
    input  logic        nfpram_fprom,
    input  logic        nfpaext,
    output wire  [7:0]  fpd
);

    logic       write_mbn;
    logic       read_mbn;
    logic       enabled;
    logic [2:0] aext_sel;
    logic [7:0] mb_bus;
    logic [7:0] mb_aext;
    logic [7:0] ibus_value;

    wire unused_ir = ^ir[7:3];

    assign write_mbn = (waddr == WADDR_WRITE_MBN);
    assign read_mbn  = (raddr == RADDR_READ_MBN);

    mbr_regfile u_regfile (
        .clk     (clk),
        .nreset  (nreset),
        .we      (write_mbn),
        .waddr   (ir[2:0]),
        .wdata   (ibus),
        .raddr_a (ir[2:0]),
        .rdata_a (mb_bus),
        .raddr_b (aext_sel),
        .rdata_b (mb_aext)
    );

    // Only writes to MB0..MB3 switch the unit out of its power-on default.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            enabled <= 1'b0;
        end else if (write_mbn && !ir[2]) begin
            enabled <= 1'b1;
        end
    end

    // Auto-index (I=R=1 with ir[9:8]=11) overrides the Z bank with the IR register field.
    always_comb begin
        aext_sel = 3'd0;
        if (waddr[4:2] == WADDR_WRITE_AR_MB) begin
            case (waddr[1:0])
                MB_CODE_P: aext_sel = 3'd0;
                MB_CODE_D: aext_sel = 3'd1;
                MB_CODE_S: aext_sel = 3'd2;
                MB_CODE_Z: aext_sel = (ir[11:8] == 4'b1111) ? ir[2:0] : 3'd3;
                default:   aext_sel = 3'd0;
            endcase
        end
    end

    assign ibus_value = mbr_value(enabled, mb_bus, nfpram_fprom);
    assign aext       = mbr_value(enabled, mb_aext, nfpram_fprom);

    assign ibus = read_mbn ? ibus_value : 8'hzz;
    assign fpd  = !nfpaext ? aext : 8'hzz;

endmodule

// File: tb/tb_mbr_unit.sv
// Bench for mbr_unit: directed tables, sweeps, front-panel pulses and a random phase
// checked against a bank-array model.
module tb_mbr_unit;

    localparam logic [4:0] WR_MBN = 5'b01111;
    localparam logic [4:0] RD_MBN = 5'b01111;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [4:0]  waddr = 5'd0;
    logic [4:0]  raddr = 5'd0;
    logic [11:0] ir = 12'd0;
    logic        nfpram_fprom = 1'b0;
    logic        nfpaext = 1'b1;
    logic        ibus_en = 1'b0;
    logic [7:0]  ibus_drv = 8'd0;
    wire  [7:0]  ibus;
    wire  [7:0]  fpd;
    logic [7:0]  aext;

    assign ibus = ibus_en ? ibus_drv : 8'hzz;

    // An undriven front-panel bus reads as all ones.
    for (genvar g = 0; g < 8; g++) begin : g_fpd_pull
        pullup (fpd[g]);
    end

    mbr_unit dut (
        .clk          (clk),
        .nreset       (nreset),
        .waddr        (waddr),
        .raddr        (raddr),
        .ir           (ir),
        .ibus         (ibus),
        .aext         (aext),
        .nfpram_fprom (nfpram_fprom),
        .nfpaext      (nfpaext),
        .fpd          (fpd)
    );

    always #5 clk = ~clk;

    // Reference model: bank contents plus the "some low bank written" flag.
    logic [7:0] m_mb [8];
    logic       m_en = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  wa;
        logic [11:0] ir;
        logic [7:0]  exp;
    } vec_t;
    vec_t tbl [13];

    function automatic logic [7:0] exp_v(input int n);
        if (m_en) return m_mb[n];
        return nfpram_fprom ? 8'h80 : 8'h00;
    endfunction

    function automatic logic [7:0] exp_aext(input logic [4:0] wa, input logic [11:0] i);
        int idx;
        idx = 0;
        if (wa >= 5'd4 && wa <= 5'd7) idx = int'(wa) - 4;
        if (wa == 5'd7 && i[11:10] == 2'b11 && i[9:8] == 2'b11) idx = int'(i[2:0]);
        return exp_v(idx);
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (waddr=%b raddr=%b ir=%h t=%0t)",
                     name, act, exp, waddr, raddr, ir, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mb[i] = 8'h00;
        m_en = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] n, input logic [7:0] v);
        @(negedge clk);
        waddr = WR_MBN;
        raddr = 5'd0;
        ir = {9'd0, n};
        ibus_en = 1'b1;
        ibus_drv = v;
        @(posedge clk);
        #1;
        waddr = 5'd0;
        ibus_en = 1'b0;
        m_mb[n] = v;
        if (n < 3'd4) m_en = 1'b1;
    endtask

    task automatic check_read(input logic [2:0] n, input string name);
        ibus_en = 1'b0;
        raddr = RD_MBN;
        ir = {9'd0, n};
        #1;
        check8(name, ibus, exp_v(int'(n)));
        raddr = 5'd0;
        #1;
    endtask

    task automatic load_pattern();
        for (int n = 0; n < 8; n++) begin
            logic [3:0] nn;
            nn = 4'(n);
            do_write(3'(n), {~nn, nn});
        end
    endtask

    initial begin
        tbl[0]  = '{5'b00100, 12'h400, 8'hF0};
        tbl[1]  = '{5'b00101, 12'h400, 8'hE1};
        tbl[2]  = '{5'b00110, 12'h400, 8'hD2};
        tbl[3]  = '{5'b00111, 12'h400, 8'hC3};
        tbl[4]  = '{5'b00111, 12'hF05, 8'hA5};
        tbl[5]  = '{5'b00111, 12'hF07, 8'h87};
        tbl[6]  = '{5'b00111, 12'hE06, 8'hC3};
        tbl[7]  = '{5'b00111, 12'hB06, 8'hC3};
        tbl[8]  = '{5'b00100, 12'hFFF, 8'hF0};
        tbl[9]  = '{5'b00110, 12'hFFE, 8'hD2};
        tbl[10] = '{5'b01111, 12'hF06, 8'hF0};
        tbl[11] = '{5'b11111, 12'hF06, 8'hF0};
        tbl[12] = '{5'b10000, 12'h000, 8'hF0};

        model_reset();
        nreset = 1'b0;
        #23;
        nreset = 1'b1;

        // Power-on defaults follow the memory map selection.
        for (int i = 0; i < 4; i++) begin
            nfpram_fprom = i[0];
            check_read(3'(i), "reset_default_read");
        end
        check8("reset_aext", aext, exp_aext(waddr, ir));
        nfpram_fprom = 1'b1;

        // Writes to high banks alone leave the defaults in place.
        do_write(3'd5, 8'h33);
        check_read(3'd5, "high_write_not_enabled");
        do_write(3'd0, 8'h11);
        check_read(3'd5, "high_after_enable");

        // Every value to every bank, then confirm the other banks survived.
        for (int n = 0; n < 8; n++) begin
            for (int v = 0; v < 256; v++) begin
                do_write(3'(n), 8'(v));
                check_read(3'(n), "write_read_back");
            end
            for (int k = 0; k < 8; k++) check_read(3'(k), "others_unchanged");
        end

        // ibus is only driven for read_mbn; elsewhere the bench owns it without contention.
        load_pattern();
        for (int r = 0; r < 32; r++) begin
            ir = 12'h005;
            raddr = 5'(r);
            if (5'(r) == RD_MBN) begin
                ibus_en = 1'b0;
                #1;
                check8("raddr_sweep_read", ibus, 8'hA5);
            end else begin
                ibus_en = 1'b1;
                ibus_drv = 8'h5A;
                #1;
                check8("raddr_sweep_float", ibus, 8'h5A);
            end
        end
        ibus_en = 1'b0;
        raddr = 5'd0;

        for (int t = 0; t < 13; t++) begin
            waddr = tbl[t].wa;
            ir = tbl[t].ir;
            #1;
            check8("aext_table", aext, tbl[t].exp);
        end

        // Auto-index sweep; bench-driven ibus must not steer the selection.
        for (int w = 4; w < 8; w++) begin
            for (int i = 12'hC00; i <= 12'hFFF; i++) begin
                logic [11:0] iv;
                iv = 12'(i);
                waddr = 5'(w);
                ir = iv;
                ibus_en = 1'b1;
                ibus_drv = ~iv[7:0];
                #1;
                check8("aext_sweep", aext, exp_aext(5'(w), iv));
            end
        end
        ibus_en = 1'b0;
        waddr = 5'd0;

        // Simultaneous read_mbn and write_mbn rewrites the value already there.
        @(negedge clk);
        waddr = WR_MBN;
        raddr = RD_MBN;
        ir = 12'h006;
        #1;
        check8("rw_same_read", ibus, 8'h96);
        @(posedge clk);
        #1;
        waddr = 5'd0;
        raddr = 5'd0;
        check_read(3'd6, "rw_same_after");

        // Front-panel strobes, with an asynchronous reset partway through.
        waddr = 5'b00110;
        ir = 12'h000;
        for (int k = 0; k < 5; k++) begin
            nfpaext = 1'b1;
            #925;
            check8("fpd_idle", fpd, 8'hFF);
            nfpaext = 1'b0;
            #25;
            check8("fpd_pulse", fpd, exp_aext(waddr, ir));
            #25;
            nfpaext = 1'b1;
            #1;
            check8("fpd_released", fpd, 8'hFF);
            if (k == 2) begin
                #3;
                nreset = 1'b0;
                model_reset();
                #1;
                check8("reset_midrun_aext", aext, nfpram_fprom ? 8'h80 : 8'h00);
                for (int n = 0; n < 8; n++) check_read(3'(n), "reset_midrun_read");
                ir = 12'h000;
                nreset = 1'b1;
                nfpram_fprom = 1'b0;
            end
        end

        // Random mix of writes, reads, collisions and AR-load selections.
        for (int it = 0; it < 600; it++) begin
            int op;
            op = int'($urandom_range(0, 3));
            nfpram_fprom = 1'($urandom_range(0, 1));
            if (op == 0) begin
                do_write(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            end else if (op == 1) begin
                check_read(3'($urandom_range(0, 7)), "rand_read");
            end else if (op == 2) begin
                waddr = 5'($urandom_range(0, 31));
                ir = 12'($urandom_range(0, 4095));
                if ($urandom_range(0, 1) == 1) ir[11:8] = 4'hF;
                #1;
                check8("rand_aext", aext, exp_aext(waddr, ir));
                waddr = 5'd0;
            end else begin
                logic [2:0] n;
                logic [7:0] v;
                n = 3'($urandom_range(0, 7));
                @(negedge clk);
                waddr = WR_MBN;
                raddr = RD_MBN;
                ir = {9'd0, n};
                #1;
                v = exp_v(int'(n));
                check8("rand_rw_same", ibus, v);
                @(posedge clk);
                #1;
                waddr = 5'd0;
                raddr = 5'd0;
                m_mb[n] = v;
                if (n < 3'd4) m_en = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
